eeg_pea_eng_feed: RTL
=====================

// Module: eeg_pea_eng_feed
// PURPOSE
//  Transmit side of the PE DIN stream. Reads activations from ARAM and weights from WRAM, then drives the
//  act/wei beat stream (DIN_VLD/DIN_RDY, ACT_LST, WEI_LST, ACT_ADD, WEI_IDX) into one EEG_PEA_ENG_PE.
//  Each activation is sent once per kernel tap, with WEI_IDX 0..CFG_CONV_WEI-1; the PE owns all accumulation.
// PARAMETERS
//  ACT_DW       8   activation width (signed)
//  WEI_DW       8   weight width (signed)
//  ARAM_ADD_AW 10   ARAM address width
//  WRAM_ADD_AW  8   WRAM address width
//  CONV_WEI_DW  3   tap-count / tap-index width
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            asynchronous active-low reset
//  CFG_START    in   1            start pulse; sampled only while IS_IDLE=1
//  CFG_ACT_BASE in   ARAM_ADD_AW  first activation address
//  CFG_ACT_LEN  in   ARAM_ADD_AW  number of activations
//  CFG_CONV_WEI in   CONV_WEI_DW  number of taps
//  CFG_WEI_BASE in   WRAM_ADD_AW  WRAM address of tap 0
//  IS_IDLE      out  1            1 in IDLE
//  ARAM_RD_ENA  out  1            ARAM read strobe; sync RAM, data valid 1 cycle later
//  ARAM_RD_ADD  out  ARAM_ADD_AW  ARAM read address
//  ARAM_RD_DAT  in   ACT_DW       ARAM read data
//  WRAM_RD_ENA  out  1            WRAM read strobe; 1-cycle latency
//  WRAM_RD_ADD  out  WRAM_ADD_AW  WRAM read address
//  WRAM_RD_DAT  in   WEI_DW       WRAM read data
//  DIN_VLD      out  1            beat valid
//  DIN_RDY      in   1            PE ready
//  ACT_LST      out  1            beat belongs to the last activation
//  WEI_LST      out  1            beat is the last tap of its activation
//  ACT_DAT      out  ACT_DW       activation
//  ACT_ADD      out  ARAM_ADD_AW  activation address
//  WEI_DAT      out  WEI_DW       weight
//  WEI_IDX      out  CONV_WEI_DW  tap index
// BEHAVIOUR
//  - Reset: all outputs 0, except IS_IDLE=1. FSM=IDLE, FIFO empty, counters 0.
//  - FSM IDLE->RUN: on CFG_START. All CFG_* are latched on that edge. CFG_START is ignored outside IDLE.
//  - FSM RUN->DRAIN: the edge that issues the final read (last activation, last tap).
//  - FSM DRAIN->IDLE: the edge that pops the final beat, i.e. DIN_VLD&DIN_RDY with ACT_LST&WEI_LST.
//  - CFG_ACT_LEN==0 or CFG_CONV_WEI==0: IDLE->RUN->IDLE, no reads and no beats.
//  - Issue stage: tap cnt t, activation cnt a. Each issue asserts WRAM_RD_ENA with ADD=CFG_WEI_BASE+t.
//    When t==0 it also asserts ARAM_RD_ENA with ADD=CFG_ACT_BASE+a.
//  - Address arithmetic wraps modulo 2^AW.
//  - Counter update: t increments; at t==CFG_CONV_WEI-1, t resets to 0 and a increments.
//  - Return stage (1 cycle after issue): ARAM_RD_DAT is held in act_hold when the ARAM read was issued, else reused.
//    The beat {act,wei,add,idx,lsts} goes into a 2-entry FIFO; the tag is piped alongside the read.
//  - Issue condition: RUN && (fifo_cnt + inflight - (DIN_VLD&DIN_RDY)) < 2. This gives 1 beat/cycle at DIN_RDY=1.
//  - Outputs are driven from the FIFO head registers. DIN_VLD = FIFO non-empty.
//  - While DIN_VLD=1 && DIN_RDY=0, all DIN outputs hold stable. No beat is ever dropped or duplicated.
//  - Latency: DIN_VLD first rises at the 2nd edge after the edge that samples CFG_START.
//  - Beat flags: WEI_LST=(idx==CFG_CONV_WEI-1). ACT_LST=(a==CFG_ACT_LEN-1) on every tap of the last activation.
//  - Simultaneous FIFO push and pop when full is legal; the count is unchanged.
//  - DIN_RDY may toggle arbitrarily. RAM read strobes only fire in RUN.
//  - Reset mid-run: everything returns to reset state immediately. An in-flight RAM read is discarded.
// STRUCTURE
//  - Package eeg_pea_eng_pkg: FEED_IDLE/RUN/DRAIN one-hot (3'b001/010/100); FIFO depth 2; DIN beat field widths.
//  - Sub-module eeg_pea_eng_feed_fifo: 2-entry sync FIFO with full/empty/cnt and concurrent push/pop.
//  - FSM, counters, issue credit and tag pipe stay in the top module.
// TESTING
//  1. BASE=10, LEN=3, WEI=3, WEI_BASE=4, RDY=1 -> 9 back-to-back beats.
//     ADD 10,10,10,11,11,11,12,12,12; IDX 0,1,2 repeating; WRAM reads 4,5,6 repeating.
//     WEI_LST on beats 3,6,9; ACT_LST on beats 7-9; IS_IDLE back to 1 after beat 9.
//  2. As 1 with DIN_RDY low for 5 cycles mid-stream -> outputs frozen during the stall.
//     No read issued while the FIFO is full+inflight; the beat sequence is identical to test 1.
//  3. Random DIN_RDY 50% with LEN=20, WEI=5 -> 100 beats match the scoreboard.
//     ARAM is read exactly 20 times and WRAM exactly 100 times.
//  4. WEI=1, LEN=4 -> every beat has WEI_LST=1, IDX=0.
//     BASE=1022 gives ADD 1022,1023,0,1 (wrap).
//  5. CFG_START pulsed in RUN with different CFG_* -> ignored; the current job completes unchanged.
//     LEN=0 -> no DIN_VLD, IS_IDLE=1 again within 2 cycles.
//  6. rst_n low for 1 cycle during beat 4 of test 1 -> DIN_VLD=0, IS_IDLE=1, no RAM strobes.
//     A new CFG_START then reproduces test 1 exactly.

Source files
------------

// File: rtl/eeg_pea_eng_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eeg_pea_eng_pkg : shared types and constants for the PE DIN feed          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package eeg_pea_eng_pkg;

    typedef enum logic [2:0] {
        FEED_IDLE  = 3'b001,
        FEED_RUN   = 3'b010,
        FEED_DRAIN = 3'b100
    } feed_state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

    // Packed beat layout: {act, wei, add, idx, act_lst, wei_lst}
    function automatic int beat_width(input int act_dw, input int wei_dw,
                                      input int add_aw, input int idx_dw);
        return act_dw + wei_dw + add_aw + idx_dw + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eeg_pea_eng_feed_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eeg_pea_eng_feed_fifo : 2-entry FIFO with registered head, push+pop safe  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module eeg_pea_eng_feed_fifo
    import eeg_pea_eng_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     push_dat_i,
    input  logic                  pop_i,
    output logic [DATA_W-1:0]     head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [FIFO_CNT_W-1:0] cnt_o
);

    logic [DATA_W-1:0]     head_q;
    logic [DATA_W-1:0]     tail_q;
    logic [FIFO_CNT_W-1:0] cnt_q;
    logic                  w_pop;
    logic                  w_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign cnt_o   = cnt_q;
    assign head_o  = head_q;
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else if (w_push && w_pop) begin
            if (full_o) begin
                head_q <= tail_q;
                tail_q <= push_dat_i;
            end else begin
                head_q <= push_dat_i;
            end
        end else if (w_push) begin
            if (empty_o) begin
                head_q <= push_dat_i;
            end else begin
                tail_q <= push_dat_i;
            end
            cnt_q <= cnt_q + FIFO_CNT_W'(1);
        end else if (w_pop) begin
            head_q <= tail_q;
            cnt_q  <= cnt_q - FIFO_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/eeg_pea_eng_feed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eeg_pea_eng_feed : reads ARAM/WRAM and streams act/wei beats into one PE  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module eeg_pea_eng_feed
    import eeg_pea_eng_pkg::*;
#(
    parameter int ACT_DW      = 8,
    parameter int WEI_DW      = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int WRAM_ADD_AW = 8,
    parameter int CONV_WEI_DW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start_i,
    input  logic [ARAM_ADD_AW-1:0] cfg_act_base_i,
    input  logic [ARAM_ADD_AW-1:0] cfg_act_len_i,
    input  logic [CONV_WEI_DW-1:0] cfg_conv_wei_i,
    input  logic [WRAM_ADD_AW-1:0] cfg_wei_base_i,
    output logic                   is_idle_o,
    output logic                   aram_rd_ena_o,
    output logic [ARAM_ADD_AW-1:0] aram_rd_add_o,
    input  logic [ACT_DW-1:0]      aram_rd_dat_i,
    output logic                   wram_rd_ena_o,
    output logic [WRAM_ADD_AW-1:0] wram_rd_add_o,
    input  logic [WEI_DW-1:0]      wram_rd_dat_i,
    output logic                   din_vld_o,
    input  logic                   din_rdy_i,
    output logic                   act_lst_o,
    output logic                   wei_lst_o,
    output logic [ACT_DW-1:0]      act_dat_o,
    output logic [ARAM_ADD_AW-1:0] act_add_o,
    output logic [WEI_DW-1:0]      wei_dat_o,
    output logic [CONV_WEI_DW-1:0] wei_idx_o
);

    localparam int BEAT_W = beat_width(ACT_DW, WEI_DW, ARAM_ADD_AW, CONV_WEI_DW);

    feed_state_e            state_q;
    logic [ARAM_ADD_AW-1:0] act_base_q, act_len_q, a_q;
    logic [CONV_WEI_DW-1:0] conv_wei_q, t_q;
    logic [WRAM_ADD_AW-1:0] wei_base_q;

    logic                   inflight_q;
    logic                   tag_aram_q, tag_act_lst_q, tag_wei_lst_q;
    logic [ARAM_ADD_AW-1:0] tag_add_q;
    logic [CONV_WEI_DW-1:0] tag_idx_q;
    logic [ACT_DW-1:0]      act_hold_q;

    logic                   w_pop, w_issue, w_job_ok, w_last_tap, w_last_act;
    logic                   w_fifo_empty, w_fifo_full;
    logic [FIFO_CNT_W-1:0]  w_fifo_cnt;
    logic [2:0]             w_credit;
    logic [ACT_DW-1:0]      w_act;
    logic [BEAT_W-1:0]      w_push_beat, w_head;

    assign w_pop      = din_vld_o && din_rdy_i;
    assign w_job_ok   = (act_len_q != '0) && (conv_wei_q != '0);
    assign w_last_tap = (t_q == conv_wei_q - CONV_WEI_DW'(1));
    assign w_last_act = (a_q == act_len_q - ARAM_ADD_AW'(1));

    // Slots already committed: queued beats plus the read still returning, less this cycle's pop
    assign w_credit = 3'(w_fifo_cnt) + 3'(inflight_q) - 3'(w_pop);
    assign w_issue  = (state_q == FEED_RUN) && w_job_ok && (w_credit < 3'd2)
                      && !(w_fifo_full && !w_pop);

    assign aram_rd_ena_o = w_issue && (t_q == '0);
    assign aram_rd_add_o = act_base_q + a_q;
    assign wram_rd_ena_o = w_issue;
    assign wram_rd_add_o = wei_base_q + WRAM_ADD_AW'(t_q);

    assign is_idle_o = (state_q == FEED_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FEED_IDLE;
            act_base_q <= '0;
            act_len_q  <= '0;
            conv_wei_q <= '0;
            wei_base_q <= '0;
            t_q        <= '0;
            a_q        <= '0;
        end else begin
            case (state_q)
                FEED_IDLE: begin
                    if (cfg_start_i) begin
                        act_base_q <= cfg_act_base_i;
                        act_len_q  <= cfg_act_len_i;
                        conv_wei_q <= cfg_conv_wei_i;
                        wei_base_q <= cfg_wei_base_i;
                        t_q        <= '0;
                        a_q        <= '0;
                        state_q    <= FEED_RUN;
                    end
                end
                FEED_RUN: begin
                    if (!w_job_ok) begin
                        state_q <= FEED_IDLE;
                    end else if (w_issue) begin
                        if (w_last_tap) begin
                            t_q <= '0;
                            a_q <= a_q + ARAM_ADD_AW'(1);
                            if (w_last_act) begin
                                state_q <= FEED_DRAIN;
                            end
                        end else begin
                            t_q <= t_q + CONV_WEI_DW'(1);
                        end
                    end
                end
                FEED_DRAIN: begin
                    if (w_pop && act_lst_o && wei_lst_o) begin
                        state_q <= FEED_IDLE;
                    end
                end
                default: state_q <= FEED_IDLE;
            endcase
        end
    end

    // The activation is read only on tap 0; later taps reuse the held copy
    assign w_act       = tag_aram_q ? aram_rd_dat_i : act_hold_q;
    assign w_push_beat = {w_act, wram_rd_dat_i, tag_add_q, tag_idx_q, tag_act_lst_q, tag_wei_lst_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            tag_aram_q    <= 1'b0;
            tag_act_lst_q <= 1'b0;
            tag_wei_lst_q <= 1'b0;
            tag_add_q     <= '0;
            tag_idx_q     <= '0;
            act_hold_q    <= '0;
        end else begin
            inflight_q <= w_issue;
            if (w_issue) begin
                tag_aram_q    <= (t_q == '0);
                tag_act_lst_q <= w_last_act;
                tag_wei_lst_q <= w_last_tap;
                tag_add_q     <= aram_rd_add_o;
                tag_idx_q     <= t_q;
            end
            if (inflight_q && tag_aram_q) begin
                act_hold_q <= aram_rd_dat_i;
            end
        end
    end

    eeg_pea_eng_feed_fifo #(
        .DATA_W (BEAT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_dat_i (w_push_beat),
        .pop_i      (w_pop),
        .head_o     (w_head),
        .empty_o    (w_fifo_empty),
        .full_o     (w_fifo_full),
        .cnt_o      (w_fifo_cnt)
    );

    assign din_vld_o = !w_fifo_empty;
    assign {act_dat_o, wei_dat_o, act_add_o, wei_idx_o, act_lst_o, wei_lst_o} = w_head;

endmodule
`default_nettype wire
